// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - RV32I decode stage with registered ID/EX slot and load-use stall
// Optional macro RV_DEC_RV32M_EN enables M-extension (MUL/DIV/REM) decode.
module rv_decode_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic [XLEN-1:0]    i_pc,
    output logic [4:0]         o_rs1_addr,
    output logic [4:0]         o_rs2_addr,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [XLEN-1:0]    i_rs2_data,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ex_ready,
    output logic [XLEN-1:0]    o_pc,
    output logic [XLEN-1:0]    o_op1,
    output logic [XLEN-1:0]    o_op2,
    output logic [XLEN-1:0]    o_store_data,
    output logic [XLEN-1:0]    o_imm,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic [4:0]         o_rd,
    output logic [4:0]         o_rs1,
    output logic [4:0]         o_rs2,
    output logic               o_rd_we,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_branch,
    output logic               o_jump,
    output logic               o_illegal,
    output logic [2:0]         o_funct3
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);
`ifdef RV_DEC_RV32M_EN
    localparam logic [ALUOP_W-1:0] ALU_MUL  = ALUOP_W'(16);
`endif

    function automatic logic [ALUOP_W-1:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    assign opc = i_instr[6:0];
    assign rd  = i_instr[11:7];
    assign f3  = i_instr[14:12];
    assign rs1 = i_instr[19:15];
    assign rs2 = i_instr[24:20];
    assign f7  = i_instr[31:25];

    assign o_rs1_addr = rs1;
    assign o_rs2_addr = rs2;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = XLEN'($signed(i_instr[31:20]));
    assign imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));

    logic               legal, writes, is_load, is_store, is_branch, is_jump;
    logic [ALUOP_W-1:0] dec_aluop;
    logic [XLEN-1:0]    dec_op1, dec_op2, dec_sd, dec_imm;

    always_comb begin
        legal     = 1'b0;
        writes    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        dec_aluop = ALU_ADD;
        dec_op1   = '0;
        dec_op2   = '0;
        dec_sd    = '0;
        dec_imm   = '0;
        case (opc)
            OPC_OP: begin
                dec_op1 = i_rs1_data;
                dec_op2 = i_rs2_data;
                writes  = 1'b1;
                if (f7 == 7'b0000000) begin
                    legal     = 1'b1;
                    dec_aluop = f3_alu(f3);
                end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    legal     = 1'b1;
                    dec_aluop = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                end
`ifdef RV_DEC_RV32M_EN
                else if (f7 == 7'b0000001) begin
                    legal     = 1'b1;
                    dec_aluop = ALU_MUL | ALUOP_W'(f3);
                end
`endif
            end
            OPC_OPIMM: begin
                dec_op1   = i_rs1_data;
                dec_op2   = imm_i;
                dec_imm   = imm_i;
                writes    = 1'b1;
                legal     = 1'b1;
                dec_aluop = f3_alu(f3);
                if (f3 == 3'd1) begin
                    legal = (f7 == 7'b0000000);
                end else if (f3 == 3'd5) begin
                    legal     = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    dec_aluop = f7[5] ? ALU_SRA : ALU_SRL;
                end
            end
            OPC_LOAD: begin
                dec_op1 = i_rs1_data;
                dec_op2 = imm_i;
                dec_imm = imm_i;
                writes  = 1'b1;
                is_load = 1'b1;
                legal   = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            end
            OPC_STORE: begin
                dec_op1  = i_rs1_data;
                dec_op2  = imm_s;
                dec_imm  = imm_s;
                dec_sd   = i_rs2_data;
                is_store = 1'b1;
                legal    = (f3 <= 3'd2);
            end
            OPC_BRANCH: begin
                dec_op1   = i_rs1_data;
                dec_op2   = i_rs2_data;
                dec_imm   = imm_b;
                dec_aluop = ALU_SUB;
                is_branch = 1'b1;
                legal     = (f3 != 3'd2) && (f3 != 3'd3);
            end
            OPC_LUI: begin
                dec_op2 = imm_u;
                dec_imm = imm_u;
                writes  = 1'b1;
                legal   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op1 = i_pc;
                dec_op2 = imm_u;
                dec_imm = imm_u;
                writes  = 1'b1;
                legal   = 1'b1;
            end
            OPC_JAL: begin
                dec_op1 = i_pc;
                dec_op2 = XLEN'(4);
                dec_imm = imm_j;
                writes  = 1'b1;
                is_jump = 1'b1;
                legal   = 1'b1;
            end
            OPC_JALR: begin
                dec_op1 = i_pc;
                dec_op2 = XLEN'(4);
                dec_imm = imm_i;
                writes  = 1'b1;
                is_jump = 1'b1;
                legal   = (f3 == 3'd0);
            end
            default: ;
        endcase
        // Illegal instructions still issue, but carry no operands and no side effects.
        if (!legal) begin
            dec_aluop = ALU_ADD;
            dec_op1   = '0;
            dec_op2   = '0;
            dec_sd    = '0;
        end
    end

    logic uses_rs1, uses_rs2;
    assign uses_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    assign uses_rs2 = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

    logic valid_q, valid_d;
    logic rd_we_q, mem_read_q, mem_write_q, branch_q, jump_q, illegal_q;
    logic [XLEN-1:0]    pc_q, op1_q, op2_q, sd_q, imm_q;
    logic [ALUOP_W-1:0] aluop_q;
    logic [4:0]         rd_q, rs1_q, rs2_q;
    logic [2:0]         f3_q;

    logic hazard, accept, load_en;
    assign hazard = i_valid && valid_q && mem_read_q && (rd_q != 5'd0) &&
                    ((uses_rs1 && rs1 == rd_q) || (uses_rs2 && rs2 == rd_q));
    assign o_ready = !hazard && (!valid_q || i_ex_ready);
    assign accept  = i_valid && o_ready;
    assign load_en = accept && !i_flush;

    always_comb begin
        valid_d = valid_q;
        if (i_flush)         valid_d = 1'b0;
        else if (accept)     valid_d = 1'b1;
        else if (i_ex_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            sd_q        <= '0;
            imm_q       <= '0;
            aluop_q     <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            f3_q        <= '0;
            rd_we_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load_en) begin
                pc_q        <= i_pc;
                op1_q       <= dec_op1;
                op2_q       <= dec_op2;
                sd_q        <= dec_sd;
                imm_q       <= dec_imm;
                aluop_q     <= dec_aluop;
                rd_q        <= rd;
                rs1_q       <= uses_rs1 ? rs1 : 5'd0;
                rs2_q       <= uses_rs2 ? rs2 : 5'd0;
                f3_q        <= f3;
                rd_we_q     <= legal && writes && (rd != 5'd0);
                mem_read_q  <= legal && is_load;
                mem_write_q <= legal && is_store;
                branch_q    <= legal && is_branch;
                jump_q      <= legal && is_jump;
                illegal_q   <= !legal;
            end else if (!valid_d) begin
                // Bubbles carry no control side effects downstream.
                rd_we_q     <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                branch_q    <= 1'b0;
                jump_q      <= 1'b0;
                illegal_q   <= 1'b0;
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_pc         = pc_q;
    assign o_op1        = op1_q;
    assign o_op2        = op2_q;
    assign o_store_data = sd_q;
    assign o_imm        = imm_q;
    assign o_aluop      = aluop_q;
    assign o_rd         = rd_q;
    assign o_rs1        = rs1_q;
    assign o_rs2        = rs2_q;
    assign o_funct3     = f3_q;
    assign o_rd_we      = rd_we_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_write  = mem_write_q;
    assign o_branch     = branch_q;
    assign o_jump       = jump_q;
    assign o_illegal    = illegal_q;

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Parametrised RV32I decode stage with a registered ID/EX output slot, valid/ready handshakes on both sides, full immediate generation and load-use hazard stalling. Sits between the fetch stage and the execute stage, reading rs1/rs2 from the register file combinationally in the decode cycle. Replaces the single-shot decoder FSM with a one-instruction-per-cycle pipelined stage.

## Interface
- XLEN, 32, operand/immediate width; immediates sign-extended to XLEN.
- ALUOP_W, 5, ALU opcode width; must be ≥5.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  fetch presents instruction
- o_ready  out  1  decode accepts this cycle
- i_instr  in  32  instruction word
- i_pc  in  XLEN  instruction address
- o_rs1_addr / o_rs2_addr  out  5  regfile read addresses, combinational from i_instr[19:15] / [24:20]
- i_rs1_data / i_rs2_data  in  XLEN  regfile read data, same cycle
- i_flush  in  1  synchronous pipeline flush
- o_valid  out  1  output slot holds an instruction
- i_ex_ready  in  1  execute consumes slot
- o_pc, o_op1, o_op2, o_store_data, o_imm  out  XLEN  registered payload
- o_aluop  out  ALUOP_W  ALU operation
- o_rd, o_rs1, o_rs2  out  5  destination / source indices (for forwarding)
- o_rd_we, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal  out  1  control flags
- o_funct3  out  3  branch condition / memory size

## Operation
- ALU ops: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9. Immediate forms use the same codes.
- OP (0110011): op1=rs1, op2=rs2; SUB/SRA need funct7=0100000, all others 0000000.
- OP-IMM (0010011): op2=I-imm; SLLI/SRLI need funct7=0000000, SRAI 0100000.
- LOAD (0000011): ADD, op1=rs1, op2=I-imm, mem_read=1; funct3 ∈ {000,001,010,100,101}.
- STORE (0100011): ADD, op1=rs1, op2=S-imm, store_data=rs2, mem_write=1, rd_we=0; funct3 ∈ {000,001,010}.
- BRANCH (1100011): SUB, op1=rs1, op2=rs2, imm=B-imm, branch=1, rd_we=0; funct3 010/011 illegal.
- LUI: op1=0, op2=U-imm, ADD. AUIPC: op1=pc, op2=U-imm, ADD.
- JAL: op1=pc, op2=4, ADD, imm=J-imm, jump=1. JALR (funct3=000): same, op1=pc, o_imm=I-imm, jump=1, o_rs1 valid.
- rd_we = 1 only for legal writers with rd≠0.
- Any other opcode or illegal funct field: o_illegal=1, rd_we=mem_read=mem_write=branch=jump=0, still issued.
- o_imm always carries the format's sign-extended immediate; 0 for R-type.
- Load-use hazard: slot holds valid load with rd≠0 and incoming instruction reads that register (rs1 for all but LUI/AUIPC/JAL; rs2 for OP/STORE/BRANCH) → o_ready=0; if i_ex_ready, slot loads a bubble (o_valid=0).

## Timing
- Reset: o_valid=0, all payload and flag outputs 0.
- Latency 1: instruction accepted at edge N appears on outputs after edge N.
- Accept when i_valid && o_ready. o_ready = !hazard && (!o_valid || i_ex_ready).
- Slot held stable while o_valid && !i_ex_ready.
- Simultaneous consume and accept: slot replaced, no bubble.
- i_flush: o_valid=0 after the edge; any same-cycle accepted input is dropped; flush overrides hazard and accept.
- Reset mid-operation clears slot immediately (async).

## Configuration
- RV_DEC_RV32M_EN defined: OP with funct7=0000001 decodes MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23 (by funct3). Undefined: those encodings flag o_illegal.

## Test plan
- ADDI x5,x1,-3 (0xFFD08293), rs1_data=10 → next cycle o_valid=1, op1=10, op2=0xFFFFFFFD, aluop=0, rd=5, rd_we=1.
- SW x2,8(x3) with rs1=0x100, rs2=0xAB → op2=8, store_data=0xAB, mem_write=1, rd_we=0.
- LW x4,0(x1) then ADD x6,x4,x4 back-to-back, ex_ready=1 → one bubble cycle, ADD issues one cycle later.
- i_ex_ready=0 for 3 cycles with i_valid=1 → o_ready=0, outputs unchanged; release → ready next cycle.
- i_flush with valid slot and i_valid=1 → o_valid=0 next cycle, instruction discarded.
- 0x02208033 (MUL) → aluop=16 with RV_DEC_RV32M_EN, o_illegal=1 without.
